// File: rtl/serial_cmp_pkg.sv
// Shared types and helpers for the serial magnitude comparator.
//   cmp_state_t : FSM state encoding (idle / scanning slices)
//   flip_sign   : maps an operand's MSB so that a signed compare becomes unsigned
package cmp_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StScan
    } cmp_state_t;

    // Inverting the sign bit of both two's-complement operands preserves their
    // order under an unsigned compare. Returns the MSB as the unsigned
    // compare should see it.
    function automatic logic flip_sign(input logic msb, input logic is_signed);
        return msb ^ is_signed;
    endfunction

endpackage

// File: rtl/serial_cmp_if.sv
// Request/response bundle between the lab controller and serial_cmp.
//   start, a, b, is_signed : request from the controller (master)
//   busy, done             : handshake status from the comparator (slave)
//   eq, neq, gt, lt        : registered compare results, held between requests
interface serial_cmp_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             busy;
    logic             done;
    logic             eq;
    logic             neq;
    logic             gt;
    logic             lt;

    modport master (
        output start, a, b, is_signed,
        input  busy, done, eq, neq, gt, lt
    );

    modport slave (
        input  start, a, b, is_signed,
        output busy, done, eq, neq, gt, lt
    );
endinterface

// File: rtl/serial_cmp_chunk_cmp.sv
// Combinational W-bit unsigned slice comparator.
//   a_i, b_i : slice operands
//   eq_o     : a_i == b_i
//   gt_o     : a_i >  b_i
//   lt_o     : a_i <  b_i
module chunk_cmp #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         eq_o,
    output logic         gt_o,
    output logic         lt_o
);

    assign eq_o = (a_i == b_i);
    assign gt_o = (a_i > b_i);
    assign lt_o = (a_i < b_i);

endmodule

// File: rtl/serial_cmp.sv
// Multi-cycle WIDTH-bit magnitude comparator, signed or unsigned. Scans the
// latched operands MSB-first one CHUNK-bit slice per clock and finishes at the
// first differing slice (or after slice 0 when equal).
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   cmp_io : request (start/a/b/is_signed) and registered status/results
//            (busy/done/eq/neq/gt/lt)
// WIDTH must be a positive multiple of CHUNK.
module serial_cmp
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input logic         clk,
    input logic         rst,
    serial_cmp_if.slave cmp_io
);

    localparam int unsigned NChunk = WIDTH / CHUNK;
    localparam int unsigned IdxW   = (NChunk > 1) ? $clog2(NChunk) : 1;
    localparam logic [IdxW-1:0] IdxTop = IdxW'(NChunk - 1);

    cmp_state_t       state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sign_q, sign_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             eq_q, eq_d;
    logic             neq_q, neq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;

    logic [WIDTH-1:0] a_cmp, b_cmp;
    logic [CHUNK-1:0] slice_a, slice_b;
    logic             slice_eq, slice_gt, slice_lt;

    // Operands as seen by the unsigned slice compare.
    always_comb begin
        a_cmp            = a_q;
        b_cmp            = b_q;
        a_cmp[WIDTH-1]   = flip_sign(a_q[WIDTH-1], sign_q);
        b_cmp[WIDTH-1]   = flip_sign(b_q[WIDTH-1], sign_q);
    end

    assign slice_a = a_cmp[32'(idx_q) * CHUNK +: CHUNK];
    assign slice_b = b_cmp[32'(idx_q) * CHUNK +: CHUNK];

    chunk_cmp #(
        .W (CHUNK)
    ) u_chunk_cmp (
        .a_i  (slice_a),
        .b_i  (slice_b),
        .eq_o (slice_eq),
        .gt_o (slice_gt),
        .lt_o (slice_lt)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sign_d  = sign_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        eq_d    = eq_q;
        neq_d   = neq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;

        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (cmp_io.start) begin
                    a_d     = cmp_io.a;
                    b_d     = cmp_io.b;
                    sign_d  = cmp_io.is_signed;
                    idx_d   = IdxTop;
                    busy_d  = 1'b1;
                    state_d = StScan;
                end
            end
            StScan: begin
                // Results are only written here, so they hold between requests.
                if (!slice_eq || (idx_q == '0)) begin
                    eq_d    = slice_eq;
                    gt_d    = slice_gt;
                    lt_d    = slice_lt;
                    neq_d   = !slice_eq;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            neq_q   <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            eq_q    <= eq_d;
            neq_q   <= neq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    assign cmp_io.busy = busy_q;
    assign cmp_io.done = done_q;
    assign cmp_io.eq   = eq_q;
    assign cmp_io.neq  = neq_q;
    assign cmp_io.gt   = gt_q;
    assign cmp_io.lt   = lt_q;

endmodule
